mips_cpu_multiplier: RTL and testbench

//  Multi-cycle shift-add multiplier for MULT/MULTU; the inverse-operation companion to the divider.

---
 rtl/mips_cpu_muldiv_pkg.sv | 20 ++
 rtl/mips_cpu_abs_neg.sv | 37 +++
 rtl/mips_cpu_multiplier.sv | 116 +++++++++++
 tb/tb_mips_cpu_multiplier.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/mips_cpu_muldiv_pkg.sv
// rtl/mips_cpu_muldiv_pkg.sv - shared types and widths for the multiply/divide units
//
// Purpose: common FSM state type and datapath width shared by the HI/LO
// multiplier and divider, so both units present the same start/done
// behaviour to the CPU stall logic.
// Contents:
//   mult_state_t  IDLE / RUN / DONE
//   MULDIV_WIDTH  default operand width (32)

package mips_cpu_muldiv_pkg;

  localparam int MULDIV_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mult_state_t;

endpackage

// File: rtl/mips_cpu_abs_neg.sv
// rtl/mips_cpu_abs_neg.sv - operand magnitude and double-width conditional negate
//
// Purpose: purely combinational sign handling for the signed multiply and
// divide paths. Converts two WIDTH-bit operands to unsigned magnitudes when
// is_signed is set, and conditionally two's-complement negates a 2*WIDTH-bit
// value for the final sign fix-up.
// Ports:
//   is_signed  in   1        treat a/b as two's complement
//   a, b       in   WIDTH    raw operands
//   a_mag      out  WIDTH    |a| (or a when unsigned)
//   b_mag      out  WIDTH    |b| (or b when unsigned)
//   negate     in   1        negate value
//   value      in   2*WIDTH  unsigned magnitude result
//   result     out  2*WIDTH  value or -value

module mips_cpu_abs_neg
  import mips_cpu_muldiv_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH
) (
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [WIDTH-1:0]     a_mag,
  output logic [WIDTH-1:0]     b_mag,
  input  logic                 negate,
  input  logic [2*WIDTH-1:0]   value,
  output logic [2*WIDTH-1:0]   result
);

  // The most negative value negates to itself, which read as unsigned is
  // exactly 2^(WIDTH-1): the correct magnitude, so no extra bit is needed.
  assign a_mag  = (is_signed && a[WIDTH-1]) ? -a : a;
  assign b_mag  = (is_signed && b[WIDTH-1]) ? -b : b;
  assign result = negate ? -value : value;

endmodule

// File: rtl/mips_cpu_multiplier.sv
// rtl/mips_cpu_multiplier.sv - multi-cycle shift-add multiplier for MULT/MULTU
//
// Purpose: computes the 2*WIDTH-bit product of two WIDTH-bit operands for the
// HI/LO path, one shift-add step per cycle, WIDTH steps per operation. Signed
// operands are multiplied as magnitudes and the product is negated at the end.
// Ports:
//   clk           in   1      clock
//   reset         in   1      synchronous, active-high
//   start         in   1      request, honoured only in IDLE or DONE
//   is_signed     in   1      1 = MULT, 0 = MULTU (sampled with start)
//   Multiplicand  in   WIDTH  operand A (sampled with start)
//   Multiplier    in   WIDTH  operand B (sampled with start)
//   ProductHi     out  WIDTH  product upper half
//   ProductLo     out  WIDTH  product lower half
//   busy          out  1      high while iterating
//   done          out  1      result valid, held until next accepted start

module mips_cpu_multiplier
  import mips_cpu_muldiv_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] Multiplicand,
  input  logic [WIDTH-1:0] Multiplier,
  output logic [WIDTH-1:0] ProductHi,
  output logic [WIDTH-1:0] ProductLo,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  mult_state_t        state;
  mult_state_t        state_next;
  logic [2*WIDTH-1:0] acc;        // {hi, lo}; multiplier bits drain out of lo
  logic [WIDTH-1:0]   mcand;      // multiplicand magnitude
  logic               neg;        // product must be negated at the end
  logic [CW-1:0]      count;

  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     sum;        // {carry, hi}
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] prod_fixed;
  logic               accept;
  logic               op_zero;

  mips_cpu_abs_neg #(.WIDTH(WIDTH)) u_abs_neg (
    .is_signed (is_signed),
    .a         (Multiplicand),
    .b         (Multiplier),
    .a_mag     (a_mag),
    .b_mag     (b_mag),
    .negate    (neg),
    .value     (acc_next),
    .result    (prod_fixed)
  );

  assign accept  = start && (state == IDLE || state == DONE);
  assign op_zero = (Multiplicand == '0) || (Multiplier == '0);

  always_comb begin
    // The carry out of the add is consumed by the same cycle's right shift,
    // so it never needs to be held in a register between iterations.
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
    acc_next = {sum, acc[WIDTH-1:1]};

    state_next = state;
    case (state)
      IDLE, DONE: if (start) state_next = op_zero ? DONE : RUN;
      RUN:        if (count == LAST) state_next = DONE;
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      acc       <= '0;
      mcand     <= '0;
      neg       <= 1'b0;
      count     <= '0;
      ProductHi <= '0;
      ProductLo <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        mcand     <= a_mag;
        acc       <= {{WIDTH{1'b0}}, b_mag};
        neg       <= is_signed & (Multiplicand[WIDTH-1] ^ Multiplier[WIDTH-1]);
        count     <= '0;
        ProductHi <= '0;
        ProductLo <= '0;
        // A zero operand skips the iterations; the cleared product is final.
        done      <= op_zero;
        busy      <= ~op_zero;
      end else if (state == RUN) begin
        acc   <= acc_next;
        count <= count + CW'(1);
        if (count == LAST) begin
          {ProductHi, ProductLo} <= prod_fixed;
          done <= 1'b1;
          busy <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mips_cpu_multiplier.sv
// tb/tb_mips_cpu_multiplier.sv - self-checking bench for mips_cpu_multiplier

module tb_mips_cpu_multiplier;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        is_signed;
  logic [31:0] Multiplicand;
  logic [31:0] Multiplier;
  logic [31:0] ProductHi;
  logic [31:0] ProductLo;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

  mips_cpu_multiplier #(.WIDTH(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .is_signed    (is_signed),
    .Multiplicand (Multiplicand),
    .Multiplier   (Multiplier),
    .ProductHi    (ProductHi),
    .ProductLo    (ProductLo),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: sign-extend (or zero-extend) to 64 bits and multiply; the low
  // 64 bits of that product are the exact result in either mode.
  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [63:0] xa, xb;
    xa = s ? {{32{a[31]}}, a} : {32'b0, a};
    xb = s ? {{32{b[31]}}, b} : {32'b0, b};
    return xa * xb;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h7FFF_FFFF;
      1: return 32'h8000_0000;
      2: return 32'h0000_0001;
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Drive start at a negedge (cycle 0) and release it one cycle later.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
    @(negedge clk);
    start = 1'b1; Multiplicand = a; Multiplier = b; is_signed = s;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits (bounded) for done; lat counts cycles from the start cycle.
  task automatic wait_done(inout int lat, inout int busy_cycles);
    while (!done && lat < 40) begin
      if (busy) busy_cycles++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic [63:0] exp, input string tag);
    int lat, bc;
    logic zero;
    zero = (a == 0) || (b == 0);
    issue(a, b, s);
    lat = 1; bc = 0;
    wait_done(lat, bc);
    check({tag, " latency"}, 64'(lat), zero ? 64'd1 : 64'd33);
    check({tag, " product"}, {ProductHi, ProductLo}, exp);
    check({tag, " busy cycles"}, 64'(bc), zero ? 64'd0 : 64'd32);
  endtask

  initial begin
    int lat, bc;
    logic [31:0] a, b;
    logic s;

    reset = 1'b1; start = 1'b0; is_signed = 1'b0;
    Multiplicand = '0; Multiplier = '0;
    repeat (3) @(negedge clk);
    check("reset product", {ProductHi, ProductLo}, 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    reset = 1'b0;

    run_op(32'd7, 32'd6, 1'b0, 64'h0000_0000_0000_002A, "u 7*6");
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, "u max*max");
    run_op(32'hFFFF_FFFD, 32'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1, "s -3*5");
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001, "s -1*-1");
    run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, "s min*min");
    run_op(32'd0, 32'h1234_5678, 1'b0, 64'd0, "u zero");
    run_op(32'd0, 32'h1234_5678, 1'b1, 64'd0, "s zero");
    run_op(32'h1234_5678, 32'd0, 1'b1, 64'd0, "s zero b");

    // start during RUN is ignored
    issue(32'hFFFF_FFF9, 32'd1000, 1'b1);
    lat = 1; bc = 0;
    while (lat < 10) begin @(negedge clk); lat++; end
    start = 1'b1; Multiplicand = 32'h55; Multiplier = 32'h66; is_signed = 1'b0;
    @(negedge clk); lat++;
    start = 1'b0;
    wait_done(lat, bc);
    check("ignored start latency", 64'(lat), 64'd33);
    check("ignored start product", {ProductHi, ProductLo},
          ref_mul(32'hFFFF_FFF9, 32'd1000, 1'b1));

    // back-to-back start from DONE
    start = 1'b1; Multiplicand = 32'h0001_0003; Multiplier = 32'h0002_0007; is_signed = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check("b2b done dropped", 64'(done), 64'd0);
    check("b2b product cleared", {ProductHi, ProductLo}, 64'd0);
    lat = 1; bc = 0;
    wait_done(lat, bc);
    check("b2b latency", 64'(lat), 64'd33);
    check("b2b product", {ProductHi, ProductLo}, 64'h0000_0002_000D_0015);

    // reset in the middle of RUN
    issue(32'h00AB_CDEF, 32'h0000_1234, 1'b0);
    lat = 1;
    while (lat < 15) begin @(negedge clk); lat++; end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrun reset product", {ProductHi, ProductLo}, 64'd0);
    check("midrun reset busy", 64'(busy), 64'd0);
    check("midrun reset done", 64'(done), 64'd0);
    run_op(32'd5, 32'd5, 1'b0, 64'd25, "after reset 5*5");

    for (int i = 0; i < 1200; i++) begin
      a = pick_operand();
      b = pick_operand();
      s = 1'($urandom_range(0, 1));
      run_op(a, b, s, ref_mul(a, b, s), $sformatf("rand %0d %h*%h s=%0d", i, a, b, s));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
